parking_gate_ctrl: RTL and testbench

Parametrised single-lane parking-entry controller: gates vehicle entry behind a programmable PIN, counts failed attempts to a configurable alarm threshold, times out abandoned PIN entry, tracks lot occupancy against a capacity limit, and holds the close command for a configurable number of cycles. It sits between the entry/exit loop sensors, the PIN keypad interface and the gate actuator driver. It supersedes the fixed 8-bit, 3-try controller.

---
 rtl/parking_gate_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking entry controller: PIN-gated entry with retry alarm, abandoned-entry
// timeout, occupancy tracking against lot capacity and a timed gate-close command.
module parking_gate_ctrl #(
    parameter  int unsigned PIN_W        = 32'd8,
    parameter  int unsigned PIN_DEFAULT  = 32'd72,
    parameter  int unsigned MAX_TRIES    = 32'd3,
    parameter  int unsigned PIN_TIMEOUT  = 32'd1000,
    parameter  int unsigned CLOSE_CYCLES = 32'd4,
    parameter  int unsigned CAPACITY     = 32'd16,
    localparam int unsigned OCC_W        = $clog2(CAPACITY + 32'd1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             senr_e,
    input  logic             senr_x,
    input  logic             ent_pin,
    input  logic [PIN_W-1:0] pin,
    input  logic             prog_pin,
    input  logic             car_out,
    output logic             gate_o,
    output logic             gate_cls,
    output logic             alm_pin,
    output logic             alm_blkg,
    output logic             lot_full,
    output logic [OCC_W-1:0] occupancy,
    output logic [7:0]       tries
);

    localparam int unsigned TMR_W = $clog2(PIN_TIMEOUT + 32'd1);
    localparam int unsigned CLS_W = $clog2(CLOSE_CYCLES + 32'd1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PIN_TIMEOUT - 32'd1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(CLOSE_CYCLES - 32'd1);
    localparam logic [OCC_W-1:0] OCC_CAP  = OCC_W'(CAPACITY);
    localparam logic [7:0]       TRY_MAX  = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_PIN  = 3'd1,
        ST_BAD_PIN   = 3'd2,
        ST_PIN_ALARM = 3'd3,
        ST_ENTERING  = 3'd4,
        ST_BLOCKED   = 3'd5,
        ST_CLOSING   = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [PIN_W-1:0] pin_r;
    logic [PIN_W-1:0] pin_nxt_s;
    logic [7:0]       tries_r;
    logic [7:0]       tries_nxt_s;
    logic [TMR_W-1:0] tmr_r;
    logic [TMR_W-1:0] tmr_nxt_s;
    logic [CLS_W-1:0] cls_cnt_r;
    logic [CLS_W-1:0] cls_cnt_nxt_s;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;
    logic             occ_inc_s;
    logic             match_s;
    logic             miss_s;

    logic             gate_o_r;
    logic             gate_cls_r;
    logic             alm_pin_r;
    logic             alm_blkg_r;
    logic             lot_full_r;

    assign match_s = ent_pin && (pin == pin_r);
    assign miss_s  = ent_pin && (pin != pin_r);

    // Next-state, PIN store, retry counter and timer decisions.
    always_comb begin
        state_nxt_s   = state_r;
        pin_nxt_s     = pin_r;
        tries_nxt_s   = tries_r;
        tmr_nxt_s     = tmr_r;
        cls_cnt_nxt_s = cls_cnt_r;
        occ_inc_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (prog_pin) begin
                    pin_nxt_s = pin;
                end else begin
                    pin_nxt_s = pin_r;
                end
                if (senr_e && (occ_r != OCC_CAP)) begin
                    state_nxt_s = ST_WAIT_PIN;
                    tmr_nxt_s   = {TMR_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_PIN: begin
                if (match_s) begin
                    state_nxt_s = ST_ENTERING;
                end else if (miss_s) begin
                    state_nxt_s = ST_BAD_PIN;
                    tries_nxt_s = (tries_r == 8'hFF) ? tries_r : tries_r + 8'd1;
                end else if (tmr_r == TMR_LAST) begin
                    state_nxt_s = ST_IDLE;
                    tmr_nxt_s   = {TMR_W{1'b0}};
                end else begin
                    tmr_nxt_s = tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_BAD_PIN: begin
                if (tries_r >= TRY_MAX) begin
                    state_nxt_s = ST_PIN_ALARM;
                end else begin
                    state_nxt_s = ST_WAIT_PIN;
                    tmr_nxt_s   = {TMR_W{1'b0}};
                end
            end
            ST_PIN_ALARM: begin
                // Wrong PINs here neither count nor time out; only the right PIN clears the alarm.
                if (match_s) begin
                    state_nxt_s = ST_ENTERING;
                end else begin
                    state_nxt_s = ST_PIN_ALARM;
                end
            end
            ST_ENTERING: begin
                tries_nxt_s = 8'd0;
                if (senr_e && senr_x) begin
                    state_nxt_s = ST_BLOCKED;
                end else if (senr_x) begin
                    state_nxt_s   = ST_CLOSING;
                    cls_cnt_nxt_s = {CLS_W{1'b0}};
                    occ_inc_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_ENTERING;
                end
            end
            ST_BLOCKED: begin
                if (match_s) begin
                    state_nxt_s   = ST_CLOSING;
                    cls_cnt_nxt_s = {CLS_W{1'b0}};
                    occ_inc_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_BLOCKED;
                end
            end
            ST_CLOSING: begin
                if (cls_cnt_r == CLS_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    cls_cnt_nxt_s = {CLS_W{1'b0}};
                end else begin
                    cls_cnt_nxt_s = cls_cnt_r + {{(CLS_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy: an admission and a departure in the same cycle cancel out.
    always_comb begin
        occ_nxt_s = occ_r;
        if (occ_inc_s && !car_out) begin
            occ_nxt_s = (occ_r == OCC_CAP) ? occ_r : occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
        end else if (!occ_inc_s && car_out) begin
            occ_nxt_s = (occ_r == {OCC_W{1'b0}}) ? occ_r : occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // State, datapath registers and outputs decoded from the next state so they change on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pin_r      <= PIN_W'(PIN_DEFAULT);
            tries_r    <= 8'd0;
            tmr_r      <= {TMR_W{1'b0}};
            cls_cnt_r  <= {CLS_W{1'b0}};
            occ_r      <= {OCC_W{1'b0}};
            gate_o_r   <= 1'b0;
            gate_cls_r <= 1'b0;
            alm_pin_r  <= 1'b0;
            alm_blkg_r <= 1'b0;
            lot_full_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pin_r      <= pin_nxt_s;
            tries_r    <= tries_nxt_s;
            tmr_r      <= tmr_nxt_s;
            cls_cnt_r  <= cls_cnt_nxt_s;
            occ_r      <= occ_nxt_s;
            gate_o_r   <= (state_nxt_s == ST_ENTERING) || (state_nxt_s == ST_BLOCKED);
            gate_cls_r <= (state_nxt_s == ST_CLOSING);
            alm_pin_r  <= (state_nxt_s == ST_PIN_ALARM);
            alm_blkg_r <= (state_nxt_s == ST_BLOCKED);
            lot_full_r <= (occ_nxt_s == OCC_CAP);
        end
    end

    assign gate_o    = gate_o_r;
    assign gate_cls  = gate_cls_r;
    assign alm_pin   = alm_pin_r;
    assign alm_blkg  = alm_blkg_r;
    assign lot_full  = lot_full_r;
    assign occupancy = occ_r;
    assign tries     = tries_r;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed vector table, hand-written corner
// sequences, then random traffic compared against a behavioural model.
module tb_parking_gate_ctrl;

    localparam int CAP  = 2;
    localparam int TO   = 8;
    localparam int CLS  = 4;
    localparam int MAXT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       senr_e = 1'b0, senr_x = 1'b0, ent_pin = 1'b0, prog_pin = 1'b0, car_out = 1'b0;
    logic [7:0] pin = 8'd0;
    logic       gate_o, gate_cls, alm_pin, alm_blkg, lot_full;
    logic [1:0] occupancy;
    logic [7:0] tries;

    int checks   = 0;
    int failures = 0;

    parking_gate_ctrl #(
        .PIN_W(8), .PIN_DEFAULT(72), .MAX_TRIES(MAXT), .PIN_TIMEOUT(TO),
        .CLOSE_CYCLES(CLS), .CAPACITY(CAP)
    ) dut (
        .clock(clock), .reset(reset), .senr_e(senr_e), .senr_x(senr_x),
        .ent_pin(ent_pin), .pin(pin), .prog_pin(prog_pin), .car_out(car_out),
        .gate_o(gate_o), .gate_cls(gate_cls), .alm_pin(alm_pin), .alm_blkg(alm_blkg),
        .lot_full(lot_full), .occupancy(occupancy), .tries(tries)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode 0 idle, 1 awaiting PIN, 2 rejected, 3 locked out,
    // 4 gate open, 5 jammed, 6 closing.
    int         m_mode, m_wait, m_left, m_tries, m_occ;
    logic [7:0] m_pin;

    task automatic model_step(input bit rst, e, x, ep, input logic [7:0] p, input bit pp, co);
        int  nmode;
        bit  inc, good, bad;
        if (rst) begin
            m_mode = 0; m_wait = 0; m_left = 0; m_tries = 0; m_occ = 0; m_pin = 8'd72;
            return;
        end
        good  = ep && (p == m_pin);
        bad   = ep && (p != m_pin);
        nmode = m_mode;
        inc   = 1'b0;
        case (m_mode)
            0: begin
                if (pp) m_pin = p;
                if (e && m_occ < CAP) begin nmode = 1; m_wait = 0; end
            end
            1: begin
                if (good) nmode = 4;
                else if (bad) begin
                    nmode = 2;
                    if (m_tries < 255) m_tries = m_tries + 1;
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait == TO) nmode = 0;
                end
            end
            2: begin
                if (m_tries >= MAXT) nmode = 3;
                else begin nmode = 1; m_wait = 0; end
            end
            3: if (good) nmode = 4;
            4: begin
                m_tries = 0;
                if (e && x) nmode = 5;
                else if (x) begin nmode = 6; inc = 1'b1; m_left = CLS; end
            end
            5: if (good) begin nmode = 6; inc = 1'b1; m_left = CLS; end
            6: begin
                m_left = m_left - 1;
                if (m_left == 0) nmode = 0;
            end
            default: nmode = 0;
        endcase
        m_mode = nmode;
        if (inc && !co) m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
        else if (!inc && co) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
    endtask

    task automatic step(input bit rst, e, x, ep, input logic [7:0] p, input bit pp, co);
        @(negedge clock);
        reset = rst; senr_e = e; senr_x = x; ent_pin = ep; pin = p; prog_pin = pp; car_out = co;
        @(posedge clock);
        model_step(rst, e, x, ep, p, pp, co);
        #1;
    endtask

    // tr < 0 marks the retry count as not checked for that sample
    task automatic check_outs(input string name, input int go, gc, ap, ab, lf, oc, tr);
        logic [7:0] tr_v;
        logic [1:0] oc_v;
        tr_v = tr[7:0];
        oc_v = oc[1:0];
        checks++;
        if (gate_o !== go[0] || gate_cls !== gc[0] || alm_pin !== ap[0] || alm_blkg !== ab[0] ||
            lot_full !== lf[0] || occupancy !== oc_v || (tr >= 0 && tries !== tr_v)) begin
            failures++;
            $display("FAIL %s: got go=%b gc=%b ap=%b ab=%b lf=%b occ=%0d tries=%0d, want go=%0d gc=%0d ap=%0d ab=%0d lf=%0d occ=%0d tries=%0d",
                     name, gate_o, gate_cls, alm_pin, alm_blkg, lot_full, occupancy, tries,
                     go, gc, ap, ab, lf, oc, tr);
        end
    endtask

    task automatic check_model(input string name);
        check_outs(name, (m_mode == 4 || m_mode == 5) ? 1 : 0, (m_mode == 6) ? 1 : 0,
                   (m_mode == 3) ? 1 : 0, (m_mode == 5) ? 1 : 0, (m_occ == CAP) ? 1 : 0,
                   m_occ, m_tries);
    endtask

    typedef struct {
        bit         e, x, ep;
        logic [7:0] p;
        bit         pp, co;
        int         go, gc, ap, ab, lf, oc, tr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit e, x, ep, logic [7:0] p, bit pp, co,
                                int go, gc, ap, ab, lf, oc, tr);
        vec_t v;
        v.e = e; v.x = x; v.ep = ep; v.p = p; v.pp = pp; v.co = co;
        v.go = go; v.gc = gc; v.ap = ap; v.ab = ab; v.lf = lf; v.oc = oc; v.tr = tr;
        tbl.push_back(v);
    endfunction

    initial begin
        //  e  x  ep  pin   pp co |go gc ap ab lf occ tries
        add(1, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 0, 0, 0);   // to WAIT_PIN
        add(0, 0, 1, 8'd72, 0, 0,  1, 0, 0, 0, 0, 0, 0);   // correct PIN opens
        add(0, 0, 0, 8'd0,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'd0,  0, 0,  0, 1, 0, 0, 0, 1, 0);   // car through, close
        add(0, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 0, 1, 0);   // back to IDLE
        add(1, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 8'd5,  0, 0,  0, 0, 0, 0, 0, 1, 1);   // wrong PIN 1
        add(0, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 8'd5,  0, 0,  0, 0, 0, 0, 0, 1, 2);   // wrong PIN 2
        add(0, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 0, 1, 2);
        add(0, 0, 1, 8'd5,  0, 0,  0, 0, 0, 0, 0, 1, 3);   // wrong PIN 3
        add(0, 0, 0, 8'd0,  0, 0,  0, 0, 1, 0, 0, 1, 3);   // alarm
        add(0, 0, 1, 8'd5,  0, 0,  0, 0, 1, 0, 0, 1, 3);   // miss ignored in alarm
        add(0, 0, 1, 8'd72, 0, 0,  1, 0, 0, 0, 0, 1, -1);  // right PIN clears alarm
        add(1, 1, 0, 8'd0,  0, 0,  1, 0, 0, 1, 0, 1, 0);   // blocked
        add(0, 0, 1, 8'd5,  0, 0,  1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 8'd0,  0, 0,  1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 8'd72, 0, 0,  0, 1, 0, 0, 1, 2, 0);   // PIN releases block, lot full
        add(0, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0, 1, 2, 0);
        add(0, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0, 1, 2, 0);
        add(0, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0, 1, 2, 0);
        add(0, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 0, 8'd0,  0, 0,  0, 0, 0, 0, 1, 2, 0);   // full: arrival ignored
        add(0, 0, 1, 8'd72, 0, 0,  0, 0, 0, 0, 1, 2, 0);   // so PIN has no effect
        add(0, 0, 0, 8'd0,  0, 1,  0, 0, 0, 0, 0, 1, 0);   // departure

        step(1, 0, 0, 0, 8'd0, 0, 0);
        step(1, 0, 0, 0, 8'd0, 0, 0);
        check_outs("reset_state", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(0, tbl[i].e, tbl[i].x, tbl[i].ep, tbl[i].p, tbl[i].pp, tbl[i].co);
            check_outs($sformatf("vec%0d", i), tbl[i].go, tbl[i].gc, tbl[i].ap, tbl[i].ab,
                       tbl[i].lf, tbl[i].oc, tbl[i].tr);
        end

        // Timeout: a PIN arriving one edge after the timeout is ignored.
        step(0, 1, 0, 0, 8'd0, 0, 0);
        for (int i = 0; i < TO; i++) begin
            step(0, 0, 0, 0, 8'd0, 0, 0);
            check_outs("timeout_wait", 0, 0, 0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 1, 8'd72, 0, 0);
        check_outs("timeout_late_pin", 0, 0, 0, 0, 0, 1, 0);

        // A PIN on the last waiting edge is still accepted.
        step(0, 1, 0, 0, 8'd0, 0, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 1, 8'd72, 0, 0);
        check_outs("timeout_last_pin", 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 8'd0, 0, 1);
        check_outs("inc_with_car_out", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < CLS - 1; i++) step(0, 0, 0, 0, 8'd0, 0, 0);
        check_outs("close_last", 0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 8'd0, 0, 0);
        check_outs("close_done", 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 8'd0, 0, 1);
        check_outs("car_out_dec", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 8'd0, 0, 1);
        check_outs("car_out_at_zero", 0, 0, 0, 0, 0, 0, 0);

        // PIN programming, programming ignored outside IDLE, reset restores default PIN.
        step(0, 0, 0, 0, 8'h33, 1, 0);
        step(0, 1, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 1, 8'd72, 0, 0);
        check_outs("old_pin_rejected", 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 0, 8'h55, 1, 0);
        step(0, 0, 0, 1, 8'h55, 0, 0);
        check_outs("prog_in_wait_ignored", 0, 0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 1, 8'h33, 0, 0);
        check_outs("new_pin_accepted", 1, 0, 0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 8'd0, 0, 0);
        check_outs("entering_clears_tries", 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 8'h33, 0, 0);
        check_outs("reset_mid_entering", 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 1, 8'd72, 0, 0);
        check_outs("default_pin_restored", 1, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        step(1, 0, 0, 0, 8'd0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit         r_rst, r_e, r_x, r_ep, r_pp, r_co;
            logic [7:0] r_p;
            r_rst = ($urandom_range(0, 299) == 0);
            r_e   = ($urandom_range(0, 2) == 0);
            r_x   = ($urandom_range(0, 2) == 0);
            r_ep  = ($urandom_range(0, 2) == 0);
            r_pp  = ($urandom_range(0, 19) == 0);
            r_co  = ($urandom_range(0, 5) == 0);
            r_p   = ($urandom_range(0, 1) == 0) ? m_pin : 8'($urandom_range(0, 255));
            step(r_rst, r_e, r_x, r_ep, r_p, r_pp, r_co);
            check_model("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
